// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader into the program store with a big-endian fetch read port
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fetch_stall,
  input  logic [31:0]       InsAddr,
  output logic [31:0]       InsData
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] len_max = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] one_w = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] one_a = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] two_a = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] three_a = ADDR_W'(3);
  state_t state;
  logic [7:0] mem [MEM_BYTES];
  logic [ADDR_W:0] cnt, len_q;
  logic [ADDR_W-1:0] a;
  logic len_ok, accept, unused_addr;
  assign len_ok = len != '0 && len[1:0] == 2'b00 && len <= len_max;
  assign accept = state == LOAD && in_valid;
  assign in_ready = state == LOAD;
  assign busy = state == LOAD;
  assign fetch_stall = state == LOAD;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      err <= 1'b0;
    end else begin
      err <= start && state != LOAD && !len_ok;
      if (accept) begin
        cnt <= cnt + one_w;
        if (cnt == len_q - one_w) state <= DONE;
      end else if (start && state != LOAD && len_ok) begin
        state <= LOAD;
        cnt <= '0;
        len_q <= len;
      end
    end
  always_ff @(posedge clk)
    if (accept) mem[cnt[ADDR_W-1:0]] <= in_data;
  assign a = InsAddr[ADDR_W-1:0];
  assign unused_addr = ^InsAddr[31:ADDR_W];
  assign InsData = {mem[a], mem[a + one_a], mem[a + two_a], mem[a + three_a]};
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed checks of imem_loader against a behavioural model
module tb_imem_loader;
  localparam int MB = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [10:0] len = '0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, busy, done, err, fetch_stall;
  logic [31:0] InsAddr = '0;
  logic [31:0] InsData;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [7:0] ref_mem [MB];
  bit known [MB];
  bit m_load = 1'b0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  int m_cnt = 0;
  int m_len = 0;

  imem_loader #(.MEM_BYTES(MB), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done), .err(err), .fetch_stall(fetch_stall),
    .InsAddr(InsAddr), .InsData(InsData)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load = 0;
      m_done = 0;
      m_err = 0;
      m_cnt = 0;
      m_len = 0;
    end else begin
      m_err = 0;
      if (m_load) begin
        if (in_valid) begin
          ref_mem[m_cnt] = in_data;
          known[m_cnt] = 1;
          m_cnt++;
          if (m_cnt == m_len) begin
            m_load = 0;
            m_done = 1;
          end
        end
      end else if (start) begin
        if (int'(len) != 0 && int'(len) % 4 == 0 && int'(len) <= MB) begin
          m_load = 1;
          m_done = 0;
          m_cnt = 0;
          m_len = int'(len);
        end else m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int a;
      a = int'(InsAddr % MB);
      check("in_ready", 32'(in_ready), 32'(m_load));
      check("busy", 32'(busy), 32'(m_load));
      check("fetch_stall", 32'(fetch_stall), 32'(m_load));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      if (known[a] && known[(a+1)%MB] && known[(a+2)%MB] && known[(a+3)%MB])
        check("insdata", InsData, {ref_mem[a], ref_mem[(a+1)%MB], ref_mem[(a+2)%MB], ref_mem[(a+3)%MB]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len = 11'(l);
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    InsAddr = addr;
    #1;
    check(name, InsData, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    do_start(8);
    check("start_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) send(8'(i * 17));
    check("load1_done", 32'(done), 1);
    check("load1_ready", 32'(in_ready), 0);
    read_check("rd0", 32'h0, 32'h00112233);
    read_check("rd4", 32'h4, 32'h44556677);
    read_check("rd2", 32'h2, 32'h22334455);
    read_check("rd_upper", 32'h404, 32'h44556677);
    do_start(8);
    for (int i = 0; i < 8; i++) begin
      check("toggle_stall", 32'(fetch_stall), 1);
      send(8'(i * 17));
      if (i < 7) step();
    end
    check("toggle_done", 32'(done), 1);
    read_check("toggle_rd0", 32'h0, 32'h00112233);
    for (int k = 0; k < 3; k++) begin
      do_start(k == 0 ? 6 : k == 1 ? 0 : MB + 4);
      check("bad_len_err", 32'(err), 1);
      check("bad_len_done", 32'(done), 1);
      step();
      check("bad_len_err_gone", 32'(err), 0);
    end
    read_check("bad_len_mem", 32'h4, 32'h44556677);
    do_start(MB);
    for (int i = 0; i < MB; i++)
      send(i < 8 ? 8'(i * 17) : i == MB - 2 ? 8'hAA : i == MB - 1 ? 8'hBB : 8'($urandom));
    check("full_done", 32'(done), 1);
    read_check("rd_wrap", 32'(MB - 2), 32'hAABB0011);
    do_start(8);
    for (int i = 0; i < 3; i++) send(8'(i * 17));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    read_check("mid_rst_mem", 32'h0, 32'h00112233);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(busy), 0);
    do_start(4);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    read_check("rd_deadbeef", 32'h0, 32'hDEADBEEF);
    read_check("rd_beyond_len", 32'h4, 32'h44556677);
    do_start(8);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        start = 1'b1;
        len = 11'd4;
      end
      send(8'(8'h10 + i));
      start = 1'b0;
      if (i == 4) check("restart_no_err", 32'(err), 0);
      if (i == 5) check("restart_ignored", 32'(done), 0);
    end
    check("restart_done", 32'(done), 1);
    read_check("restart_rd4", 32'h4, 32'h14151617);
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (3) step();
    in_valid = 1'b0;
    read_check("done_no_write", 32'h0, 32'h10111213);
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom % 16) == 0;
      len = ($urandom % 3 == 0) ? 11'($urandom % 1100) : 11'(4 * (1 + $urandom % 32));
      in_valid = ($urandom % 4) != 0;
      in_data = 8'($urandom);
      InsAddr = ($urandom % 2 == 0) ? 32'($urandom % 128) : 32'($urandom);
      if ($urandom % 600 == 0) begin
        #1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else step();
    end
    start = 1'b0;
    in_valid = 1'b0;
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
